// File: rtl/ram_arbiter.sv
// ============================================================================
// Module   : ram_arbiter
// Brief    : Two-requester round-robin arbiter with bounded bursts that
//            sequences accesses onto a single-port RAM. The optional grant and
//            wait statistics are enabled by defining RAM_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_arbiter #(
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int RAM_DATA_WIDTH = 32,
    parameter int MAX_BURST      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                i_req_valid,
    input  logic [1:0]                i_req_we,
    input  logic [RAM_ADDR_WIDTH-1:0] i_req_addr0,
    input  logic [RAM_ADDR_WIDTH-1:0] i_req_addr1,
    input  logic [RAM_DATA_WIDTH-1:0] i_req_wdata0,
    input  logic [RAM_DATA_WIDTH-1:0] i_req_wdata1,
    output logic [1:0]                o_req_ready,
    output logic [1:0]                o_rsp_valid,
    output logic [RAM_DATA_WIDTH-1:0] o_rsp_data,
    output logic                      o_ram_we,
    output logic [RAM_ADDR_WIDTH-1:0] o_ram_addr,
    output logic [RAM_DATA_WIDTH-1:0] o_ram_wr_data,
`ifdef RAM_ARB_STATS_EN
    output logic [15:0]               o_gnt_cnt0,
    output logic [15:0]               o_gnt_cnt1,
    output logic [7:0]                o_wait_max,
`endif
    input  logic [RAM_DATA_WIDTH-1:0] i_ram_rd_data
);

    localparam int                 c_CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_BURST = c_CNT_W'(MAX_BURST);
    localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);

    logic                      r_holder;
    logic [c_CNT_W-1:0]        r_count;
    logic [1:0]                r_rsp_valid;
    logic [RAM_DATA_WIDTH-1:0] r_rsp_data;

    logic [1:0]                w_grant;
    logic                      w_pick;
    logic                      w_gnt_idx;

    // Grant is held off while in reset so nothing reaches the RAM.
    always_comb begin
        w_grant = 2'b00;
        w_pick  = 1'b0;
        if (rst_n) begin
            case (i_req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11: begin
                    w_pick  = (r_count < c_MAX_BURST) ? r_holder : ~r_holder;
                    w_grant = w_pick ? 2'b10 : 2'b01;
                end
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign w_gnt_idx   = w_grant[1];
    assign o_req_ready = w_grant;

    always_comb begin
        o_ram_we      = 1'b0;
        o_ram_addr    = '0;
        o_ram_wr_data = '0;
        if (w_grant[0]) begin
            o_ram_we      = i_req_we[0];
            o_ram_addr    = i_req_addr0;
            o_ram_wr_data = i_req_wdata0;
        end else if (w_grant[1]) begin
            o_ram_we      = i_req_we[1];
            o_ram_addr    = i_req_addr1;
            o_ram_wr_data = i_req_wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_holder    <= 1'b1;
            r_count     <= c_MAX_BURST;
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= '0;
        end else begin
            if (|w_grant) begin
                if (w_gnt_idx == r_holder) begin
                    r_count <= (r_count == c_MAX_BURST) ? c_MAX_BURST : r_count + c_ONE;
                end else begin
                    r_holder <= w_gnt_idx;
                    r_count  <= c_ONE;
                end
            end else begin
                // An idle cycle ends the burst, so the next tie flips owner.
                r_count <= c_MAX_BURST;
            end
            r_rsp_valid <= w_grant & ~i_req_we;
            if (|(w_grant & ~i_req_we)) begin
                r_rsp_data <= i_ram_rd_data;
            end
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;

`ifdef RAM_ARB_STATS_EN
    logic [15:0] r_gnt_cnt [2];
    logic [7:0]  r_wait    [2];
    logic [7:0]  r_wait_max;
    logic [7:0]  w_wait_nxt [2];
    logic [7:0]  w_wait_big;

    assign w_wait_nxt[0] = (i_req_valid[0] && !w_grant[0]) ?
                           ((r_wait[0] == 8'hFF) ? 8'hFF : r_wait[0] + 8'd1) : 8'd0;
    assign w_wait_nxt[1] = (i_req_valid[1] && !w_grant[1]) ?
                           ((r_wait[1] == 8'hFF) ? 8'hFF : r_wait[1] + 8'd1) : 8'd0;
    assign w_wait_big    = (w_wait_nxt[0] > w_wait_nxt[1]) ? w_wait_nxt[0] : w_wait_nxt[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                r_gnt_cnt[k] <= '0;
                r_wait[k]    <= '0;
            end
            r_wait_max <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (w_grant[k] && r_gnt_cnt[k] != 16'hFFFF) begin
                    r_gnt_cnt[k] <= r_gnt_cnt[k] + 16'd1;
                end
                r_wait[k] <= w_wait_nxt[k];
            end
            if (w_wait_big > r_wait_max) begin
                r_wait_max <= w_wait_big;
            end
        end
    end

    assign o_gnt_cnt0 = r_gnt_cnt[0];
    assign o_gnt_cnt1 = r_gnt_cnt[1];
    assign o_wait_max = r_wait_max;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Scoreboard bench for ram_arbiter with a behavioural RAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_we, req_ready, rsp_valid;
    logic [7:0]  req_addr0, req_addr1, ram_addr;
    logic [31:0] req_wdata0, req_wdata1, rsp_data, ram_wr_data, ram_rd_data;
    logic        ram_we;
`ifdef RAM_ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
    logic [7:0]  wait_max;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t exp_q[$];

    logic [31:0] mem [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ram_rd_data = mem[ram_addr];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wr_data;

    ram_arbiter #(.RAM_ADDR_WIDTH(8), .RAM_DATA_WIDTH(32), .MAX_BURST(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid   (req_valid),
        .i_req_we      (req_we),
        .i_req_addr0   (req_addr0),
        .i_req_addr1   (req_addr1),
        .i_req_wdata0  (req_wdata0),
        .i_req_wdata1  (req_wdata1),
        .o_req_ready   (req_ready),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_data    (rsp_data),
        .o_ram_we      (ram_we),
        .o_ram_addr    (ram_addr),
        .o_ram_wr_data (ram_wr_data),
`ifdef RAM_ARB_STATS_EN
        .o_gnt_cnt0    (gnt_cnt0),
        .o_gnt_cnt1    (gnt_cnt1),
        .o_wait_max    (wait_max),
`endif
        .i_ram_rd_data (ram_rd_data)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic apply(input logic [1:0] v, input logic [1:0] we,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] exp_rdy, input bit push,
                         input logic [31:0] exp_data, input string nm);
        req_valid  = v;
        req_we     = we;
        req_addr0  = a0;
        req_addr1  = a1;
        req_wdata0 = d0;
        req_wdata1 = d1;
        #1;
        check(nm, 64'(req_ready), 64'(exp_rdy));
        if (push) exp_q.push_back('{valid: exp_rdy, data: exp_data, due: cyc + 1});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every presented response must match the queue head
    // and arrive exactly one cycle after its grant.
    always @(negedge clk) begin
        if (rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'h0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_valid", 64'(rsp_valid), 64'(e.valid));
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("rsp_cycle", 64'(cyc), 64'(e.due));
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            check("rsp_missing", 64'(rsp_valid), 64'(exp_q[0].valid));
            void'(exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq [12];
        seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10,
                2'b01, 2'b01, 2'b01, 2'b01};

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(2'b11, 2'b00, 8'h20, 8'h21, 32'h0, 32'h0, 2'b00, 0, 32'h0, "rst_ready");
            tick();
        end
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_data", 64'(rsp_data), 64'h0);
        rst_n = 1'b1;

        apply(2'b11, 2'b11, 8'h20, 8'h21, 32'hAAAA5555, 32'h5555AAAA, 2'b01, 0, 32'h0, "tie_after_rst");
        tick();
        apply(2'b10, 2'b11, 8'h20, 8'h21, 32'hAAAA5555, 32'h5555AAAA, 2'b10, 0, 32'h0, "req1_alone");
        tick();

        apply(2'b01, 2'b01, 8'h10, 8'h00, 32'hDEADBEEF, 32'h0, 2'b01, 0, 32'h0, "wr_grant");
        check("wr_ram_we", 64'(ram_we), 64'h1);
        check("wr_ram_addr", 64'(ram_addr), 64'h10);
        check("wr_ram_wdata", 64'(ram_wr_data), 64'hDEADBEEF);
        tick();
        apply(2'b01, 2'b00, 8'h10, 8'h00, 32'h0, 32'h0, 2'b01, 1, 32'hDEADBEEF, "rd_grant");
        check("rd_ram_we", 64'(ram_we), 64'h0);
        tick();
        apply(2'b00, 2'b11, 8'h33, 8'h44, 32'h1, 32'h2, 2'b00, 0, 32'h0, "idle");
        check("idle_ram_we", 64'(ram_we), 64'h0);
        check("idle_ram_addr", 64'(ram_addr), 64'h0);
        check("idle_ram_wdata", 64'(ram_wr_data), 64'h0);
        tick();

        apply(2'b10, 2'b10, 8'h00, 8'hFF, 32'h0, 32'h12345678, 2'b10, 0, 32'h0, "wr1_ff");
        check("wr1_ram_addr", 64'(ram_addr), 64'hFF);
        tick();
        apply(2'b01, 2'b00, 8'hFF, 8'h00, 32'h0, 32'h0, 2'b01, 1, 32'h12345678, "rd0_ff");
        tick();
        apply(2'b10, 2'b00, 8'h00, 8'hFF, 32'h0, 32'h0, 2'b10, 1, 32'h12345678, "rd1_ff");
        tick();
        apply(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b00, 0, 32'h0, "idle2");
        tick();

        for (int i = 0; i < 12; i++) begin
            apply(2'b11, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0, seq[i], 1,
                  (seq[i] == 2'b01) ? 32'hDEADBEEF : 32'hAAAA5555, "contention");
            tick();
        end
        apply(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b00, 0, 32'h0, "idle3");
        tick();

        for (int i = 0; i < 2; i++) begin
            apply(2'b01, 2'b00, 8'h10, 8'h00, 32'h0, 32'h0, 2'b01, 1, 32'hDEADBEEF, "burst_req0");
            tick();
        end
        apply(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b00, 0, 32'h0, "burst_idle");
        tick();
        apply(2'b11, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0, 2'b10, 1, 32'hAAAA5555, "burst_break");
        tick();

        apply(2'b01, 2'b00, 8'h10, 8'h00, 32'h0, 32'h0, 2'b01, 0, 32'h0, "rd_before_rst");
        rst_n = 1'b0;
        tick();
        check("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("midrst_rsp_data", 64'(rsp_data), 64'h0);
        rst_n = 1'b1;
        apply(2'b11, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0, 2'b01, 1, 32'hDEADBEEF, "tie_after_rst2");
        tick();

        for (int i = 0; i < 4; i++) begin
            apply(2'b01, 2'b01, 8'h50 + 8'(i), 8'h00, 32'h100 + 32'(i), 32'h0, 2'b01, 0, 32'h0, "stat_wr0");
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            apply(2'b10, 2'b10, 8'h00, 8'h60 + 8'(i), 32'h0, 32'h200 + 32'(i), 2'b10, 0, 32'h0, "stat_wr1");
            tick();
        end
`ifdef RAM_ARB_STATS_EN
        check("gnt_cnt0", 64'(gnt_cnt0), 64'd5);
        check("gnt_cnt1", 64'(gnt_cnt1), 64'd3);
`endif
        apply(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b00, 0, 32'h0, "final_idle");
        tick();
        tick();
        check("rsp_queue_drained", 64'(exp_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
Name:
ram_arbiter

Overview:
- Two-requester arbiter and sequencer for a single-port RAM: combinational-read, synchronous-write, one access per cycle.
- Gives each client a valid/ready request channel and a registered read-response channel.
- Drives the RAM's write-data, write-enable and address ports.
- Arbitration is round-robin with a bounded burst: a requester keeps the port for up to MAX_BURST consecutive granted cycles under contention.

Parameters:
- RAM_ADDR_WIDTH, 8, RAM address width.
- RAM_DATA_WIDTH, 32, RAM data width.
- MAX_BURST, 4, maximum consecutive grants to one requester while the other waits; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- i_req_valid  input  2  per-requester request valid; bit k = requester k.
- i_req_we  input  2  per-requester write (1) / read (0).
- i_req_addr0, i_req_addr1  input  RAM_ADDR_WIDTH each  request address.
- i_req_wdata0, i_req_wdata1  input  RAM_DATA_WIDTH each  write data.
- o_req_ready  output  2  grant; combinational, one-hot or zero.
- o_rsp_valid  output  2  read-data-valid pulse, per requester.
- o_rsp_data  output  RAM_DATA_WIDTH  registered read data (shared).
- o_ram_we  output  1  to RAM write enable.
- o_ram_addr  output  RAM_ADDR_WIDTH  to RAM address.
- o_ram_wr_data  output  RAM_DATA_WIDTH  to RAM write data.
- i_ram_rd_data  input  RAM_DATA_WIDTH  from RAM combinational read data.

Behaviour:
- State:
  - holder h (1 bit).
  - burst count c, width $clog2(MAX_BURST+1).
  - o_rsp_valid and o_rsp_data registers.
- Reset (rst_n=0 at edge):
  - h=1, c=MAX_BURST, o_rsp_valid=0, o_rsp_data=0.
  - In-flight read response is discarded; o_rsp_valid is 0 in the cycle after reset.
- Grant (combinational, same cycle):
  - No valid: no grant.
  - One valid: grant it.
  - Both valid: grant h if c<MAX_BURST, else grant ~h.
- Transfer: occurs when i_req_valid[k] & o_req_ready[k]. A requester holds valid, we, addr and wdata stable until granted; dropping valid before grant is allowed.
- Counter update on a granted cycle to k:
  - k==h: c=min(c+1,MAX_BURST).
  - k!=h: h=k, c=1.
- Counter update on an idle cycle: c=MAX_BURST, h unchanged, so the next tie goes to ~h.
- RAM drive:
  - Granted: o_ram_addr/o_ram_wr_data are muxed from the granted requester; o_ram_we = granted we.
  - Ungranted: addr=0, wdata=0, we=0.
- Read (we=0) granted to k in cycle N:
  - o_rsp_data <= i_ram_rd_data at the end of N.
  - o_rsp_valid[k]=1 in cycle N+1 only (1-cycle latency).
  - o_rsp_data holds its value when no read is granted.
- Write: no response; the RAM updates at the end of the granted cycle.
- A read to the same address in any later cycle, by either requester, returns the new data.
- Back-to-back reads: one response per cycle; o_rsp_valid may stay high continuously.
- MAX_BURST=1: strict alternation under continuous contention.
- Idle cycle inside a burst: breaks the burst.

Optional Feature:
- Macro RAM_ARB_STATS_EN.
- Defined: adds outputs o_gnt_cnt0 and o_gnt_cnt1 (16 bits each).
  - Each counts transfers for its requester.
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst_n.
  - Also adds o_wait_max (8 bits): the longest number of consecutive cycles any requester held valid without a grant, saturating at 8'hFF, reset 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 3 cycles with both valid -> o_req_ready=00, o_rsp_valid=00, o_rsp_data=0. First post-reset tie grants requester 0.
- Single requester: req0 writes 32'hDEADBEEF to addr 8'h10, then reads 8'h10 -> o_ram_we=1 in the write cycle; o_rsp_valid=01 one cycle after the read grant, o_rsp_data=32'hDEADBEEF.
- Contention, MAX_BURST=4, both valid continuously for 12 cycles -> grant sequence 0,0,0,0,1,1,1,1,0,0,0,0.
- Cross-requester ordering: req1 writes 32'h12345678 to 8'hFF; the next cycle req0 reads 8'hFF -> o_rsp_valid=01, data 32'h12345678. Address wrap at 8'hFF is handled with no side effect.
- Burst break: req0 granted 2 cycles, 1 idle cycle, then both valid -> requester 1 granted first.
- Reset mid-read: read granted in cycle N, rst_n=0 at the end of N -> o_rsp_valid=00 in N+1. With RAM_ARB_STATS_EN: after 5 req0 and 3 req1 transfers, o_gnt_cnt0=5, o_gnt_cnt1=3.
